// File: rtl/frame_proto_pkg.sv
// Protocol constants and state encodings shared by the frame receiver and the
// matching frame transmitter.
package frame_proto_pkg;

    localparam logic [7:0]  HDR0        = 8'hC8;
    localparam logic [7:0]  HDR1        = 8'hD2;
    localparam logic [15:0] SOF_WORD    = 16'hC5E3;
    localparam logic [15:0] EOF_WORD    = 16'hE3C5;
    localparam int          NPIX        = 256;
    localparam int          TIMEOUT_CYC = 50000;

    typedef logic [1:0] byte_state_t;
    localparam byte_state_t B_HDR0 = 2'd0;
    localparam byte_state_t B_HDR1 = 2'd1;
    localparam byte_state_t B_LO   = 2'd2;
    localparam byte_state_t B_HI   = 2'd3;

    typedef logic [1:0] frame_state_t;
    localparam frame_state_t F_IDLE = 2'd0;
    localparam frame_state_t F_PIX  = 2'd1;
    localparam frame_state_t F_EOF  = 2'd2;

    // Pixel words carry a zero tag nibble above the 12-bit value.
    function automatic logic is_pixel(input logic [3:0] tag);
        return (tag == 4'h0);
    endfunction

endpackage

// File: rtl/uart_word_asm.sv
// Byte-level packet FSM: hunts for the two header bytes, assembles a 16-bit
// little-endian word, and aborts a stalled packet after an inter-byte timeout.
module uart_word_asm #(
    parameter logic [7:0] HDR0        = frame_proto_pkg::HDR0,
    parameter logic [7:0] HDR1        = frame_proto_pkg::HDR1,
    parameter int         TIMEOUT_CYC = frame_proto_pkg::TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte_i,
    input  logic        rx_valid_i,
    output logic        word_v_o,
    output logic [15:0] word_o,
    output logic        timeout_o
);
    import frame_proto_pkg::byte_state_t;
    import frame_proto_pkg::B_HDR0;
    import frame_proto_pkg::B_HDR1;
    import frame_proto_pkg::B_LO;
    import frame_proto_pkg::B_HI;

    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    byte_state_t   state_q, state_d;
    logic [7:0]    lo_q, lo_d;
    logic [15:0]   word_q, word_d;
    logic          word_v_q, word_v_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          expire;

    // Combinational so the frame stage can register frame_err on the very next edge.
    assign expire = (state_q != B_HDR0) && !rx_valid_i && (tmr_q == TMO_LAST);

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        word_d   = word_q;
        word_v_d = 1'b0;
        tmr_d    = tmr_q;
        if (rx_valid_i) begin
            tmr_d = '0;
            case (state_q)
                B_HDR0: begin
                    if (rx_byte_i == HDR0)
                        state_d = B_HDR1;
                end
                B_HDR1: begin
                    if (rx_byte_i == HDR1)
                        state_d = B_LO;
                    else if (rx_byte_i != HDR0)
                        state_d = B_HDR0;
                end
                B_LO: begin
                    lo_d    = rx_byte_i;
                    state_d = B_HI;
                end
                default: begin
                    word_d   = {rx_byte_i, lo_q};
                    word_v_d = 1'b1;
                    state_d  = B_HDR0;
                end
            endcase
        end else if (expire) begin
            state_d = B_HDR0;
            tmr_d   = '0;
        end else if (state_q != B_HDR0) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= B_HDR0;
            lo_q     <= '0;
            word_q   <= '0;
            word_v_q <= 1'b0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            word_q   <= word_d;
            word_v_q <= word_v_d;
            tmr_q    <= tmr_d;
        end
    end

    assign word_v_o  = word_v_q;
    assign word_o    = word_q;
    assign timeout_o = expire;

endmodule

// File: rtl/frame_rx_decoder.sv
// Frame-level decoder: turns assembled words into pixel writes, tracks the
// brightest pixel of each frame and publishes it when the frame closes cleanly.
module frame_rx_decoder #(
    parameter logic [7:0]  HDR0        = frame_proto_pkg::HDR0,
    parameter logic [7:0]  HDR1        = frame_proto_pkg::HDR1,
    parameter logic [15:0] SOF_WORD    = frame_proto_pkg::SOF_WORD,
    parameter logic [15:0] EOF_WORD    = frame_proto_pkg::EOF_WORD,
    parameter int          NPIX        = frame_proto_pkg::NPIX,
    parameter int          TIMEOUT_CYC = frame_proto_pkg::TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        pix_we,
    output logic [7:0]  pix_addr,
    output logic [11:0] pix_data,
    output logic        frame_done,
    output logic        frame_err,
    output logic [7:0]  peak_idx,
    output logic [11:0] peak_val,
    output logic [7:0]  frame_cnt
);
    import frame_proto_pkg::frame_state_t;
    import frame_proto_pkg::F_IDLE;
    import frame_proto_pkg::F_PIX;
    import frame_proto_pkg::F_EOF;
    import frame_proto_pkg::is_pixel;

    localparam logic [7:0] LAST_PIX = 8'(NPIX - 1);

    logic        word_v;
    logic [15:0] word;
    logic        tmo;

    uart_word_asm #(
        .HDR0        (HDR0),
        .HDR1        (HDR1),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_word_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_byte_i  (rx_byte),
        .rx_valid_i (rx_valid),
        .word_v_o   (word_v),
        .word_o     (word),
        .timeout_o  (tmo)
    );

    frame_state_t fstate_q, fstate_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [7:0]   run_idx_q, run_idx_d;
    logic [11:0]  run_val_q, run_val_d;
    logic         pix_we_q, pix_we_d;
    logic [7:0]   pix_addr_q, pix_addr_d;
    logic [11:0]  pix_data_q, pix_data_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [7:0]   peak_idx_q, peak_idx_d;
    logic [11:0]  peak_val_q, peak_val_d;
    logic [7:0]   frame_cnt_q, frame_cnt_d;

    always_comb begin
        fstate_d    = fstate_q;
        cnt_d       = cnt_q;
        run_idx_d   = run_idx_q;
        run_val_d   = run_val_q;
        pix_we_d    = 1'b0;
        pix_addr_d  = pix_addr_q;
        pix_data_d  = pix_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        peak_idx_d  = peak_idx_q;
        peak_val_d  = peak_val_q;
        frame_cnt_d = frame_cnt_q;
        if (tmo) begin
            fstate_d = F_IDLE;
            err_d    = 1'b1;
        end else if (word_v) begin
            case (fstate_q)
                F_IDLE: begin
                    if (word == SOF_WORD) begin
                        fstate_d  = F_PIX;
                        cnt_d     = '0;
                        run_idx_d = '0;
                        run_val_d = '0;
                    end
                end
                F_PIX: begin
                    if (is_pixel(word[15:12])) begin
                        pix_we_d   = 1'b1;
                        pix_addr_d = cnt_q;
                        pix_data_d = word[11:0];
                        // Strictly greater keeps the lowest index on ties.
                        if (word[11:0] > run_val_q) begin
                            run_val_d = word[11:0];
                            run_idx_d = cnt_q;
                        end
                        if (cnt_q == LAST_PIX)
                            fstate_d = F_EOF;
                        else
                            cnt_d = cnt_q + 8'd1;
                    end else begin
                        err_d = 1'b1;
                        if (word == SOF_WORD) begin
                            cnt_d     = '0;
                            run_idx_d = '0;
                            run_val_d = '0;
                        end else begin
                            fstate_d = F_IDLE;
                        end
                    end
                end
                default: begin
                    if (word == EOF_WORD) begin
                        done_d      = 1'b1;
                        peak_idx_d  = run_idx_q;
                        peak_val_d  = run_val_q;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        fstate_d    = F_IDLE;
                    end else if (word == SOF_WORD) begin
                        err_d     = 1'b1;
                        fstate_d  = F_PIX;
                        cnt_d     = '0;
                        run_idx_d = '0;
                        run_val_d = '0;
                    end else begin
                        err_d    = 1'b1;
                        fstate_d = F_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fstate_q    <= F_IDLE;
            cnt_q       <= '0;
            run_idx_q   <= '0;
            run_val_q   <= '0;
            pix_we_q    <= 1'b0;
            pix_addr_q  <= '0;
            pix_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            peak_idx_q  <= '0;
            peak_val_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            fstate_q    <= fstate_d;
            cnt_q       <= cnt_d;
            run_idx_q   <= run_idx_d;
            run_val_q   <= run_val_d;
            pix_we_q    <= pix_we_d;
            pix_addr_q  <= pix_addr_d;
            pix_data_q  <= pix_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            peak_idx_q  <= peak_idx_d;
            peak_val_q  <= peak_val_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign pix_we     = pix_we_q;
    assign pix_addr   = pix_addr_q;
    assign pix_data   = pix_data_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign peak_idx   = peak_idx_q;
    assign peak_val   = peak_val_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_frame_rx_decoder.sv
// Bench for frame_rx_decoder: table of frame scenarios plus hand-written
// timeout and mid-frame reset sequences; pixel writes checked via a queue.
`timescale 1ns/1ps
module tb_frame_rx_decoder;
    import frame_proto_pkg::*;

    localparam int TB_TMO = 100;
    localparam int NROWS  = 8;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        pix_we;
    logic [7:0]  pix_addr;
    logic [11:0] pix_data;
    logic        frame_done;
    logic        frame_err;
    logic [7:0]  peak_idx;
    logic [11:0] peak_val;
    logic [7:0]  frame_cnt;

    frame_rx_decoder #(.TIMEOUT_CYC(TB_TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .pix_we     (pix_we),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .peak_idx   (peak_idx),
        .peak_val   (peak_val),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [11:0] data;
    } pix_t;

    // kind: 0 ramp i*16, 1 tie at 10/200, 2 all zero, 3 descending
    // abort_kind: 0 none, 1 SOF after 100 pixels, 2 bad word after 100 pixels then SOF
    typedef struct {
        int          kind;
        bit          noise;
        int          abort_kind;
        logic [15:0] end_word;
        int          exp_done;
        int          exp_err;
        int          exp_idx;
        int          exp_val;
    } row_t;

    row_t rows [NROWS];
    pix_t exp_q [$];

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int done_seen = 0;
    int cyc = 0;
    int last_valid_cyc = 0;
    int err_cyc = 0;
    int exp_cnt = 0;
    bit gap_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) last_valid_cyc = cyc;
            if (frame_err) begin
                err_seen++;
                err_cyc = cyc;
            end
            if (frame_done) done_seen++;
            if (pix_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pix_we unexpected: addr %0d data %03h, expected no write",
                             pix_addr, pix_data);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    if (pix_addr !== e.addr || pix_data !== e.data) begin
                        errors++;
                        $display("FAIL pixel write: got addr %0d data %03h, expected addr %0d data %03h",
                                 pix_addr, pix_data, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        if (gap_mode && $urandom_range(0, 3) == 0) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_packet(input logic [15:0] w);
        send_byte(HDR0);
        send_byte(HDR1);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
    endtask

    task automatic send_pixel(input int idx, input logic [11:0] v);
        pix_t p;
        p.addr = 8'(idx);
        p.data = v;
        exp_q.push_back(p);
        send_packet({4'h0, v});
    endtask

    function automatic logic [11:0] pix_val(input int kind, input int i);
        case (kind)
            0:       return 12'(i * 16);
            1:       return (i == 10 || i == 200) ? 12'hABC : 12'(i);
            2:       return 12'h000;
            default: return 12'(12'hFFF - i);
        endcase
    endfunction

    task automatic run_row(input row_t rw, input int id);
        err_seen  = 0;
        done_seen = 0;
        if (rw.noise) begin
            send_byte(8'h00);
            send_byte(HDR0);
        end
        send_packet(SOF_WORD);
        if (rw.abort_kind != 0) begin
            for (int i = 0; i < 100; i++) send_pixel(i, 12'hFFF);
            if (rw.abort_kind == 2) send_packet(16'h1234);
            send_packet(SOF_WORD);
        end
        for (int i = 0; i < NPIX; i++) send_pixel(i, pix_val(rw.kind, i));
        send_packet(rw.end_word);
        rx_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        exp_cnt = (exp_cnt + rw.exp_done) % 256;
        check("pending pixel writes", exp_q.size(), 0);
        check("frame_done count", done_seen, rw.exp_done);
        check("frame_err count", err_seen, rw.exp_err);
        check("peak_idx", peak_idx, rw.exp_idx);
        check("peak_val", peak_val, rw.exp_val);
        check("frame_cnt", frame_cnt, exp_cnt);
        $display("row %0d: done=%0d err=%0d peak_idx=%0d peak_val=%03h frame_cnt=%0d",
                 id, done_seen, err_seen, peak_idx, peak_val, frame_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rows[0] = '{0, 1'b0, 0, EOF_WORD,   1, 0, 255, 12'hFF0};
        rows[1] = '{1, 1'b0, 0, EOF_WORD,   1, 0, 10,  12'hABC};
        rows[2] = '{0, 1'b1, 0, EOF_WORD,   1, 0, 255, 12'hFF0};
        rows[3] = '{0, 1'b0, 1, EOF_WORD,   1, 1, 255, 12'hFF0};
        rows[4] = '{3, 1'b0, 0, EOF_WORD,   1, 0, 0,   12'hFFF};
        rows[5] = '{2, 1'b0, 0, 16'h1234,   0, 1, 0,   12'hFFF};
        rows[6] = '{2, 1'b0, 0, EOF_WORD,   1, 0, 0,   12'h000};
        rows[7] = '{1, 1'b0, 2, EOF_WORD,   1, 1, 10,  12'hABC};

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset pix_we", pix_we, 0);
        check("reset pix_addr", pix_addr, 0);
        check("reset pix_data", pix_data, 0);
        check("reset frame_done", frame_done, 0);
        check("reset frame_err", frame_err, 0);
        check("reset peak_idx", peak_idx, 0);
        check("reset peak_val", peak_val, 0);
        check("reset frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int r = 0; r < NROWS; r++) begin
            gap_mode = r[0];
            run_row(rows[r], r);
        end

        // Timeout: stall after the low byte of the SOF packet.
        gap_mode  = 1'b0;
        err_seen  = 0;
        done_seen = 0;
        begin
            logic [15:0] w;
            w = SOF_WORD;
            send_byte(HDR0);
            send_byte(HDR1);
            send_byte(w[7:0]);
        end
        rx_valid = 1'b0;
        for (int k = 0; k < 400 && err_seen == 0; k++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check("timeout frame_err count", err_seen, 1);
        if (err_seen > 0)
            check("timeout latency", err_cyc - last_valid_cyc, TB_TMO + 1);
        check("timeout frame_done count", done_seen, 0);
        check("timeout frame_cnt held", frame_cnt, exp_cnt);
        $display("timeout: frame_err after %0d cycles", err_cyc - last_valid_cyc);
        run_row(rows[0], 100);

        // Reset in the middle of a frame.
        send_packet(SOF_WORD);
        for (int i = 0; i < 50; i++) send_pixel(i, 12'hFFF);
        rx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("partial frame writes", exp_q.size(), 0);
        rst_n = 1'b0;
        #3;
        check("async reset frame_cnt", frame_cnt, 0);
        check("async reset peak_val", peak_val, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        exp_cnt   = 0;
        err_seen  = 0;
        done_seen = 0;
        repeat (10) @(posedge clk);
        #1;
        check("post-reset frame_err count", err_seen, 0);
        $display("reset mid-frame: released, frame_cnt=%0d", frame_cnt);
        run_row(rows[0], 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
